// File: rtl/mux_n_pipe_pkg.sv
// Shared constants and helpers for the N-input pipelined selector.
package mux_pkg;

  localparam int unsigned MAX_N_IN = 16;
  localparam int unsigned CNT_W    = 16;

  // Smallest r with 2**r >= v; used to validate the select width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Widest beat record, {err, data}, with data right-aligned.
  localparam int unsigned MAX_WIDTH = 32;
  typedef struct packed {
    logic                 err;
    logic [MAX_WIDTH-1:0] data;
  } mux_beat_t;

endpackage

// File: rtl/mux_n_pipe_if.sv
// Data/handshake bundle between the selector and its neighbours.
interface mux_n_pipe_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned N_IN  = 2,
  parameter int unsigned SEL_W = 1
);

  logic [N_IN*WIDTH-1:0] D;
  logic [SEL_W-1:0]      Sel;
  logic                  In_Valid;
  logic                  In_Ready;
  logic [WIDTH-1:0]      O;
  logic                  O_Err;
  logic                  Out_Valid;
  logic                  Out_Ready;
  logic [15:0]           Beat_Cnt;

  // Environment side: supplies beats and downstream ready.
  modport master (
    output D, Sel, In_Valid, Out_Ready,
    input  In_Ready, O, O_Err, Out_Valid, Beat_Cnt
  );

  // Selector side.
  modport slave (
    input  D, Sel, In_Valid, Out_Ready,
    output In_Ready, O, O_Err, Out_Valid, Beat_Cnt
  );

endinterface

// File: rtl/mux_n_pipe_skid_buf2.sv
// Two-entry valid/ready skid buffer: output register plus one overflow entry,
// with a fully registered upstream ready.
module skid_buf2 #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] skid_q, skid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         in_fire;

  // Next-state: the skid entry always drains ahead of a new input beat.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    in_fire      = in_valid_i & in_ready_q;

    if (!out_valid_q || out_ready_i) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = in_data_i;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = in_data_i;
      skid_valid_d = 1'b1;
    end

    in_ready_d = ~skid_valid_d;
  end

  // State registers; reset empties both entries and opens the input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_data_o  = out_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/mux_n_pipe.sv
// N-input, WIDTH-bit selector with registered output, skid buffering and an
// input-side beat counter.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned N_IN  = 2,
  parameter int unsigned SEL_W = 1
) (
  input logic         CLK,
  input logic         RST_n,
  mux_n_pipe_if.slave bus
);

  localparam int unsigned BEAT_W = WIDTH + 1;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } beat_t;

  // Reject configurations the select field cannot address.
  if (SEL_W < clog2(N_IN) || N_IN > MAX_N_IN || N_IN < 2 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
    $error("mux_n_pipe: illegal WIDTH/N_IN/SEL_W combination");
  end

  beat_t             in_beat;
  beat_t             out_beat;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Select the addressed input; an unmatched select yields data 0, err 1.
  always_comb begin
    in_beat     = '0;
    in_beat.err = 1'b1;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (bus.Sel == SEL_W'(k)) begin
        in_beat.err  = 1'b0;
        in_beat.data = bus.D[k*WIDTH +: WIDTH];
      end
    end
  end

  skid_buf2 #(
    .W (BEAT_W)
  ) u_skid (
    .clk_i       (CLK),
    .rst_ni      (RST_n),
    .in_data_i   (in_beat),
    .in_valid_i  (bus.In_Valid),
    .in_ready_o  (bus.In_Ready),
    .out_data_o  (out_beat),
    .out_valid_o (bus.Out_Valid),
    .out_ready_i (bus.Out_Ready)
  );

  assign bus.O     = out_beat.data;
  assign bus.O_Err = out_beat.err;

  // Count input handshakes; wraps naturally at the counter width.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.In_Valid && bus.In_Ready) cnt_d = cnt_q + CNT_W'(1);
  end

  // Beat counter register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.Beat_Cnt = cnt_q;

endmodule
